// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: next-PC select codes, fetch FSM states,
// default reset vector and word-alignment helper.
package mips_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;
  localparam logic [1:0] PCSRC_JR  = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_pc_next.sv
// Next-PC target mux: picks sequential, branch, jump or jr target and
// forces word alignment on the result.
module pc_next
  import mips_pkg::*;
(
  input  logic [1:0]  pcsrc_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pcbranch_i,
  input  logic [31:0] pcjump_i,
  input  logic [31:0] pcjr_i,
  output logic [31:0] target_o
);

  logic [31:0] raw;

  always_comb begin
    raw = pc_i + 32'd4;
    case (pcsrc_i)
      PCSRC_BR: raw = pcbranch_i;
      PCSRC_J:  raw = pcjump_i;
      PCSRC_JR: raw = pcjr_i;
      default:  raw = pc_i + 32'd4;
    endcase
    target_o = word_align(raw);
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, runs a single-outstanding
// req/ready handshake to imem and parks one response in a skid entry on stall.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallf,
  input  logic [1:0]  pcsrcd,
  input  logic [31:0] pcbranchd,
  input  logic [31:0] pcjumpd,
  input  logic [31:0] pcjrd,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcf,
  output logic [31:0] rd,
  output logic [31:0] pcp4f,
  output logic        validf,
  output logic        missf
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  rd_q, rd_d;
  logic [31:0]  pcp4_q, pcp4_d;
  logic         valid_q, valid_d;
  logic [31:0]  skid_q, skid_d;
  logic [31:0]  skid_pcp4_q, skid_pcp4_d;
  logic [31:0]  pend_q, pend_d;

  logic [31:0]  target;
  logic [31:0]  pc_plus4;
  logic         redirect;

  pc_next u_pc_next (
    .pcsrc_i    (pcsrcd),
    .pc_i       (pc_q),
    .pcbranch_i (pcbranchd),
    .pcjump_i   (pcjumpd),
    .pcjr_i     (pcjrd),
    .target_o   (target)
  );

  assign redirect = (pcsrcd != PCSRC_SEQ);
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rd_d        = rd_q;
    pcp4_d      = pcp4_q;
    valid_d     = valid_q;
    skid_d      = skid_q;
    skid_pcp4_d = skid_pcp4_q;
    pend_d      = pend_q;

    case (state_q)
      REQ: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_d    = target;
            valid_d = 1'b0;
          end else if (!stallf) begin
            rd_d    = imem_rdata;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end else begin
            skid_d      = imem_rdata;
            skid_pcp4_d = pc_plus4;
            pc_d        = pc_plus4;
            state_d     = HOLD;
          end
        end else if (redirect) begin
          // Request is in flight: keep the address, remember where to go.
          pend_d  = target;
          valid_d = 1'b0;
          state_d = FLUSH;
        end else if (!stallf) begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = REQ;
        end else if (!stallf) begin
          rd_d    = skid_q;
          pcp4_d  = skid_pcp4_q;
          valid_d = 1'b1;
          state_d = REQ;
        end
      end
      FLUSH: begin
        if (imem_ready) begin
          pc_d    = redirect ? target : pend_q;
          state_d = REQ;
        end else if (redirect) begin
          pend_d = target;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      rd_q        <= '0;
      pcp4_q      <= '0;
      valid_q     <= 1'b0;
      skid_q      <= '0;
      skid_pcp4_q <= '0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      pcp4_q      <= pcp4_d;
      valid_q     <= valid_d;
      skid_q      <= skid_d;
      skid_pcp4_q <= skid_pcp4_d;
      pend_q      <= pend_d;
    end
  end

  assign imem_req  = (state_q != HOLD);
  assign imem_addr = pc_q;
  assign pcf       = pc_q;
  assign rd        = rd_q;
  assign pcp4f     = pcp4_q;
  assign validf    = valid_q;
  assign missf     = !((state_q == REQ) && imem_ready);

endmodule
